// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add 16x16 multiplier.
package mult_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(15);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adder16.sv
// 16-bit carry-ripple adder; the single adder reused by every multiply iteration.
module adder16
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[WIDTH];
    end

endmodule

// File: rtl/shift_add_mult16.sv
// Multi-cycle unsigned 16x16->32 multiplier: 16 ADD/SHIFT pairs over {X,A,Q}
// using one shared carry-ripple adder.
module shift_add_mult16
    import mult_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             x_reg;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sum;
    logic             sum_cout;

    adder16 u_adder (
        .a    (a_reg),
        .b    (m_reg),
        .cin  (1'b0),
        .s    (sum),
        .cout (sum_cout)
    );

    // Product is the raw register pair; consumers qualify it with Done.
    assign Product = {a_reg, q_reg};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            m_reg <= '0;
            a_reg <= '0;
            q_reg <= '0;
            x_reg <= 1'b0;
            count <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        m_reg <= Multiplicand;
                        q_reg <= Multiplier;
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        count <= '0;
                        Busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (q_reg[0]) begin
                        {x_reg, a_reg} <= {sum_cout, sum};
                    end else begin
                        x_reg <= 1'b0;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // 33-bit logical right shift keeps the adder carry in the product.
                    {x_reg, a_reg, q_reg} <= {1'b0, x_reg, a_reg, q_reg[WIDTH-1:1]};
                    if (count == LAST_ITER) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        Done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
